// File: rtl/alarm_seq_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, timer width
// and default delay lengths, plus a helper that tells which states run the timer.
package alarm_seq_pkg;

   localparam int TMR_W = 18;

   localparam logic [TMR_W-1:0] EXIT_TICKS_DEF  = 18'd30;
   localparam logic [TMR_W-1:0] ENTRY_TICKS_DEF = 18'd15;
   localparam logic [TMR_W-1:0] SIREN_TICKS_DEF = 18'd180;

   typedef enum logic [2:0] {
      ST_DISARMED = 3'd0,
      ST_EXIT     = 3'd1,
      ST_ARMED    = 3'd2,
      ST_ENTRY    = 3'd3,
      ST_ALARM    = 3'd4
   } state_t;

   // States that own the shared delay timer while they are active.
   function automatic logic is_timed(state_t s);
      return (s == ST_EXIT) || (s == ST_ENTRY) || (s == ST_ALARM);
   endfunction

endpackage

// File: rtl/tmr_ctrl.sv
// Timer sequencing: turns a start(ticks) or stop strobe into the registered
// tmr_max / tmr_rst / tmr_en load-then-enable pattern and masks tmr_finish
// while the timer is not counting (including the load cycle).
module tmr_ctrl
   import alarm_seq_pkg::*;
(
   input  logic             clkSignal,
   input  logic             RST,
   input  logic             start,
   input  logic             stop,
   input  logic [TMR_W-1:0] ticks,
   input  logic             finish,
   output logic [TMR_W-1:0] tmr_max,
   output logic             tmr_rst,
   output logic             tmr_en,
   output logic             finish_q
);

   logic run;

   // A finish is only meaningful once the timer has been enabled after its load cycle.
   assign finish_q = finish & tmr_en;

   // Load cycle holds the timer in restart; enable follows from the next cycle while running.
   always_ff @(posedge clkSignal or posedge RST) begin
      if (RST) begin
         tmr_max <= '0;
         tmr_rst <= 1'b0;
         tmr_en  <= 1'b0;
         run     <= 1'b0;
      end else if (start) begin
         tmr_max <= ticks;
         tmr_rst <= 1'b1;
         tmr_en  <= 1'b0;
         run     <= 1'b1;
      end else if (stop) begin
         tmr_rst <= 1'b1;
         tmr_en  <= 1'b0;
         run     <= 1'b0;
      end else begin
         tmr_rst <= 1'b0;
         tmr_en  <= run;
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Arming/alarm state machine of the home-alarm module. Sequences the shared
// delay timer through exit delay, entry delay and siren duration.
// Optional build macro ALARM_SEQ_TAMPER_EN adds a level 'tamper' input that
// forces ALARM from any state (priority just below disarm_req).
module alarm_sequencer
   import alarm_seq_pkg::*;
#(
   parameter int               NZONES       = 4,
   parameter logic [NZONES-1:0] INSTANT_MASK = 4'b0001,
   parameter logic [TMR_W-1:0] EXIT_TICKS   = EXIT_TICKS_DEF,
   parameter logic [TMR_W-1:0] ENTRY_TICKS  = ENTRY_TICKS_DEF,
   parameter logic [TMR_W-1:0] SIREN_TICKS  = SIREN_TICKS_DEF
)(
   input  logic              clkSignal,
   input  logic              RST,
   input  logic              arm_req,
   input  logic              disarm_req,
   input  logic [NZONES-1:0] zone_trip,
   input  logic              tmr_finish,
`ifdef ALARM_SEQ_TAMPER_EN
   input  logic              tamper,
`endif
   output logic [TMR_W-1:0]  tmr_max,
   output logic              tmr_en,
   output logic              tmr_rst,
   output logic              siren,
   output logic              armed,
   output logic              alarm_mem,
   output logic              arm_fail,
   output logic [2:0]        state
);

   state_t           state_q;
   state_t           state_nxt;
   logic             arm_fail_nxt;
   logic             restart;
   logic             tmr_start;
   logic             tmr_stop;
   logic [TMR_W-1:0] tmr_ticks;
   logic             finish_q;

   function automatic logic [TMR_W-1:0] ticks_for(state_t s);
      case (s)
         ST_EXIT:  return EXIT_TICKS;
         ST_ENTRY: return ENTRY_TICKS;
         default:  return SIREN_TICKS;
      endcase
   endfunction

   assign state = state_q;

   // State register plus the state-derived registered outputs.
   always_ff @(posedge clkSignal or posedge RST) begin
      if (RST) begin
         state_q   <= ST_DISARMED;
         siren     <= 1'b0;
         armed     <= 1'b0;
         alarm_mem <= 1'b0;
         arm_fail  <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         siren     <= (state_nxt == ST_ALARM);
         armed     <= (state_nxt != ST_DISARMED);
         alarm_mem <= (state_nxt == ST_ALARM) | (alarm_mem & ~disarm_req);
         arm_fail  <= arm_fail_nxt;
      end
   end

   // Next state by priority disarm > (tamper) > finish > zone > arm, then timer strobes.
   always_comb begin
      state_nxt    = state_q;
      arm_fail_nxt = 1'b0;
      restart      = 1'b0;
      tmr_start    = 1'b0;
      tmr_stop     = 1'b0;
      tmr_ticks    = '0;

      if (disarm_req) begin
         state_nxt = ST_DISARMED;
      end
`ifdef ALARM_SEQ_TAMPER_EN
      else if (tamper) begin
         state_nxt = ST_ALARM;
         // Held tamper restarts the siren period once it times out.
         restart   = (state_q == ST_ALARM) && finish_q;
      end
`endif
      else begin
         case (state_q)
            ST_DISARMED: begin
               if (arm_req) begin
                  if (|zone_trip) arm_fail_nxt = 1'b1;
                  else            state_nxt    = ST_EXIT;
               end
            end
            ST_EXIT: begin
               if (finish_q) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
               if (|(zone_trip & INSTANT_MASK)) state_nxt = ST_ALARM;
               else if (|zone_trip)             state_nxt = ST_ENTRY;
            end
            ST_ENTRY: begin
               if (finish_q || |(zone_trip & INSTANT_MASK)) state_nxt = ST_ALARM;
            end
            ST_ALARM: begin
               if (finish_q) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_DISARMED;
         endcase
      end

      if (is_timed(state_nxt) && ((state_nxt != state_q) || restart)) begin
         tmr_start = 1'b1;
         tmr_ticks = ticks_for(state_nxt);
      end else if (!is_timed(state_nxt) && is_timed(state_q)) begin
         tmr_stop  = 1'b1;
      end
   end

   tmr_ctrl u_tmr_ctrl (
      .clkSignal (clkSignal),
      .RST       (RST),
      .start     (tmr_start),
      .stop      (tmr_stop),
      .ticks     (tmr_ticks),
      .finish    (tmr_finish),
      .tmr_max   (tmr_max),
      .tmr_rst   (tmr_rst),
      .tmr_en    (tmr_en),
      .finish_q  (finish_q)
   );

endmodule
